encoder_sample_scheduler: RTL and testbench
===========================================

Name: encoder_sample_scheduler

Overview:
Periodic sampler and sequencer for NUM_CH quadrature encoder channels. On a fixed sample tick it snapshots every channel's pulse_count at once and computes zero-offset position and per-period velocity. It then streams one record per channel, in channel order, over a valid/ready handshake to the active-suspension control loop. It sits between the encoder counters and the controller.

Parameters:
NUM_CH, 4, number of encoder channels (1..16)
CNT_W, 32, width of each encoder pulse count (two's complement)
VEL_W, 16, width of reported velocity (signed, saturated)
PERIOD, 50000, clk cycles per sample tick (>= NUM_CH+3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run sampling; low stops the scheduler
count_in  in  NUM_CH*CNT_W  live pulse counts; channel i at bits [i*CNT_W +: CNT_W]
zero_req  in  NUM_CH  per-channel one-cycle request: set channel home to current count
sample_valid  out  1  record on sample_* is valid
sample_ready  in  1  downstream accepts record
sample_ch  out  max(1,clog2(NUM_CH))  channel index of record
sample_pos  out  CNT_W  snapshot minus channel offset (wraps mod 2^CNT_W)
sample_vel  out  VEL_W  snapshot minus previous snapshot, saturated signed
sample_last  out  1  high with the record of channel NUM_CH-1
overrun  out  1  one-cycle pulse when a tick is dropped
overrun_cnt  out  8  saturating count of dropped ticks
busy  out  1  high in SNAP or EMIT

Behaviour:
- Reset: all outputs 0, FSM IDLE, timer 0, offsets 0, prev snapshots 0, prime flag 0.
- Timer: counts 0..PERIOD-1 while enable=1, wrapping; tick is a one-cycle pulse when timer==PERIOD-1. Cleared to 0 whenever enable=0. Free-runs in every state while enabled.
- FSM states:
  - IDLE: enable=1 -> WAIT.
  - WAIT: tick -> SNAP; enable=0 -> IDLE.
  - SNAP: one cycle. Latch all channels of count_in into snap[]. Compute pos and vel per channel. Then prev[i] <= snap value, prime <= 1, go EMIT with ch=0.
  - EMIT: sample_valid=1 with record for ch. On valid&ready: if ch==NUM_CH-1, go WAIT (or IDLE if enable=0); else ch+1.
- Latency: tick in cycle t -> SNAP in t+1 -> sample_valid for ch0 in t+2. With ready held high, records appear on NUM_CH consecutive cycles.
- Handshake rules:
  - sample_* are registered outputs and stay stable while valid=1 and ready=0.
  - valid never drops without a handshake, except on rst.
  - enable=0 during EMIT does not abort; the stream completes.
- Velocity: diff = snap - prev, computed in CNT_W bits modulo 2^CNT_W and interpreted signed, so counter wrap 0x7FFFFFFF -> 0x80000000 gives +1. diff is clamped to [-2^(VEL_W-1), 2^(VEL_W-1)-1].
- First sample after leaving IDLE (prime=0): sample_vel=0 for all channels. prime is cleared in IDLE.
- Position: sample_pos = snap - offset[ch], modulo 2^CNT_W.
- Zero: zero_req[i]=1 in any state sets offset[i] <= count_in[i] that cycle.
  - Takes effect from the next SNAP; the record currently being emitted is not altered.
  - Velocity is unaffected by zeroing.
  - zero_req coinciding with SNAP: the offset update and the snapshot use the same count_in value, so the next sample's pos reflects motion since that cycle.
- Overrun: a tick arriving in SNAP or EMIT is dropped. overrun pulses for one cycle and overrun_cnt increments, saturating at 255. The next tick samples normally. prev is not updated for a dropped tick, so the next velocity spans two periods.
- rst mid-EMIT: valid drops the next cycle and all state returns to reset values.

Test Plan:
- Reset/idle: rst 2 cycles, enable=0 for 200 cycles -> all outputs 0, no valid.
- Basic sample: NUM_CH=4, PERIOD=16, counts {10,20,30,40}, enable, ready=1.
  - First stream: pos=counts, vel=0, ch 0..3, last on ch3, valid at tick+2.
  - Counts advanced +5,-3,0,+100 -> second stream vel {5,-3,0,100}.
- Backpressure: ready=0 for 5 cycles on ch1 -> ch1 record held stable, no skip; ch2 follows ready high.
- Wrap/saturate: ch0 prev 0x7FFFFFFF -> 0x80000000 gives vel=+1; ch1 jump +40000 with VEL_W=16 -> vel=32767; jump -40000 -> -32768.
- Zero: count 500, zero_req[2] pulse, count then 520 at next tick -> ch2 pos=20, vel unaffected. Zero_req coincident with SNAP also checked.
- Overrun: hold ready=0 across a tick -> overrun pulse, overrun_cnt=1. Following stream velocity spans 2 periods. Drive 300 overruns -> overrun_cnt=255.

Source files
------------

// File: rtl/encoder_sample_scheduler.sv
// rtl/encoder_sample_scheduler.sv - periodic encoder snapshot, position/velocity calc, per-channel record stream
module encoder_sample_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int VEL_W  = 16,
  parameter int PERIOD = 50000,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH*CNT_W-1:0] count_in,
  input  logic [NUM_CH-1:0]       zero_req,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic [CH_W-1:0]         sample_ch,
  output logic [CNT_W-1:0]        sample_pos,
  output logic [VEL_W-1:0]        sample_vel,
  output logic                    sample_last,
  output logic                    overrun,
  output logic [7:0]              overrun_cnt,
  output logic                    busy
);

  localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SNAP, S_EMIT} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer;
  logic              tick;
  logic              prime;
  logic              handshake;
  logic [CH_W-1:0]   ch_nxt;

  logic [CNT_W-1:0]  cnt_c  [NUM_CH];
  logic [CNT_W-1:0]  offset [NUM_CH];
  logic [CNT_W-1:0]  prev   [NUM_CH];
  logic [CNT_W-1:0]  pos_c  [NUM_CH];
  logic [CNT_W-1:0]  pos_q  [NUM_CH];
  logic [VEL_W-1:0]  vel_c  [NUM_CH];
  logic [VEL_W-1:0]  vel_q  [NUM_CH];

  assign tick      = enable && (timer == TW'(PERIOD - 1));
  assign handshake = sample_valid && sample_ready;
  assign busy      = (state == S_SNAP) || (state == S_EMIT);
  assign ch_nxt    = sample_ch + CH_W'(1);

  always_ff @(posedge clk) begin
    if (rst || !enable || tick) timer <= '0;
    else                        timer <= timer + TW'(1);
  end

  // Difference is taken modulo 2^CNT_W so counter wrap reads as a small signed step.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] diff;
    assign cnt_c[i] = count_in[i*CNT_W +: CNT_W];
    assign diff     = cnt_c[i] - prev[i];
    assign pos_c[i] = cnt_c[i] - offset[i];
    if (VEL_W >= CNT_W) begin : g_wide
      assign vel_c[i] = prime ? VEL_W'($signed(diff)) : '0;
    end else begin : g_sat
      localparam logic signed [CNT_W-1:0] VMAX = {{(CNT_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
      localparam logic signed [CNT_W-1:0] VMIN = ~VMAX;
      assign vel_c[i] = !prime                   ? '0 :
                        ($signed(diff) > VMAX)   ? {1'b0, {(VEL_W-1){1'b1}}} :
                        ($signed(diff) < VMIN)   ? {1'b1, {(VEL_W-1){1'b0}}} :
                                                   diff[VEL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (enable) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!enable)  state_nxt = S_IDLE;
        else if (tick) state_nxt = S_SNAP;
      end
      S_SNAP: state_nxt = S_EMIT;
      S_EMIT: if (handshake && sample_last) state_nxt = enable ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Offsets update in any state; SNAP reads the pre-update offset so the
  // record in flight is computed against the old home.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        offset[i] <= '0;
        prev[i]   <= '0;
        pos_q[i]  <= '0;
        vel_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (zero_req[i]) offset[i] <= cnt_c[i];
      end
      if (state == S_IDLE) prime <= 1'b0;
      if (state == S_SNAP) begin
        prime <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          prev[i]  <= cnt_c[i];
          pos_q[i] <= pos_c[i];
          vel_q[i] <= vel_c[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_pos   <= '0;
      sample_vel   <= '0;
      sample_last  <= 1'b0;
      overrun      <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      overrun <= tick && busy;
      if (tick && busy && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
      if (state == S_SNAP) begin
        sample_valid <= 1'b1;
        sample_ch    <= '0;
        sample_pos   <= pos_c[0];
        sample_vel   <= vel_c[0];
        sample_last  <= (NUM_CH == 1);
      end else if ((state == S_EMIT) && handshake) begin
        if (sample_last) begin
          sample_valid <= 1'b0;
          sample_last  <= 1'b0;
        end else begin
          sample_ch   <= ch_nxt;
          sample_pos  <= pos_q[ch_nxt];
          sample_vel  <= vel_q[ch_nxt];
          sample_last <= (ch_nxt == LAST_CH);
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder_sample_scheduler.sv
// tb/tb_encoder_sample_scheduler.sv - directed bench for encoder_sample_scheduler
module tb_encoder_sample_scheduler;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int VEL_W  = 16;
  localparam int PERIOD = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         sample_ready = 1'b0;
  logic [3:0]   zero_req = '0;
  logic [31:0]  cnt [4];
  logic [127:0] count_in;
  logic         sample_valid, sample_last, overrun, busy;
  logic [1:0]   sample_ch;
  logic [31:0]  sample_pos;
  logic [15:0]  sample_vel;
  logic [7:0]   overrun_cnt;

  int checks = 0;
  int failures = 0;

  assign count_in = {cnt[3], cnt[2], cnt[1], cnt[0]};

  always #5 clk = ~clk;

  encoder_sample_scheduler #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .VEL_W(VEL_W), .PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .count_in(count_in), .zero_req(zero_req),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_ch(sample_ch),
    .sample_pos(sample_pos), .sample_vel(sample_vel), .sample_last(sample_last),
    .overrun(overrun), .overrun_cnt(overrun_cnt), .busy(busy)
  );

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; sample_ready = 1'b0; zero_req = '0;
    cnt = '{0, 0, 0, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!sample_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!sample_valid) begin
      failures++;
      $display("FAIL %s: valid not seen within 100 cycles", tag);
    end
  endtask

  task automatic get_rec(output logic [1:0] c, output logic [31:0] p,
                         output logic [15:0] v, output logic l);
    sample_ready = 1'b1;
    wait_valid("get_rec");
    c = sample_ch; p = sample_pos; v = sample_vel; l = sample_last;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt = '{0, 0, 0, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      checks++;
      if ({sample_valid, sample_ch, sample_pos, sample_vel, sample_last, overrun, overrun_cnt, busy} !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: valid=%0b ch=%0d pos=%0d vel=%0d last=%0b ov=%0b ovc=%0d busy=%0b, want all 0",
                 k, sample_valid, sample_ch, sample_pos, sample_vel, sample_last, overrun, overrun_cnt, busy);
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0] c; logic [31:0] p; logic [15:0] v; logic l;
    int ep [4]; int ev [4]; int n;
    do_reset();
    cnt = '{10, 20, 30, 40};
    sample_ready = 1'b1;
    enable = 1'b1;
    n = 0;
    while (!sample_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != 17) begin
      failures++;
      $display("FAIL basic_latency: valid after %0d cycles, want 17", n);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: busy=%0b, want 1", busy); end
    ep = '{10, 20, 30, 40}; ev = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(ep[i]) || v !== 16'(ev[i]) || l !== (i == 3)) begin
        failures++;
        $display("FAIL basic_s1 rec%0d: got ch=%0d pos=%0d vel=%0d last=%0b, want pos=%0d vel=%0d",
                 i, c, p, $signed(v), l, ep[i], ev[i]);
      end
    end
    cnt = '{15, 17, 30, 140};
    ep = '{15, 17, 30, 140}; ev = '{5, -3, 0, 100};
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(ep[i]) || v !== 16'(ev[i]) || l !== (i == 3)) begin
        failures++;
        $display("FAIL basic_s2 rec%0d: got ch=%0d pos=%0d vel=%0d last=%0b, want pos=%0d vel=%0d",
                 i, c, p, $signed(v), l, ep[i], ev[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] hc; logic [31:0] hp; logic [15:0] hv;
    do_reset();
    cnt = '{7, 8, 9, 10};
    sample_ready = 1'b1;
    enable = 1'b1;
    wait_valid("bp_start");
    @(negedge clk);
    hc = sample_ch; hp = sample_pos; hv = sample_vel;
    sample_ready = 1'b0;
    checks++;
    if (!sample_valid || hc !== 2'd1 || hp !== 32'd8 || hv !== 16'd0) begin
      failures++;
      $display("FAIL bp_ch1: valid=%0b ch=%0d pos=%0d vel=%0d, want 1/1/8/0", sample_valid, hc, hp, hv);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (!sample_valid || sample_ch !== hc || sample_pos !== hp || sample_vel !== hv || sample_last !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc%0d: valid=%0b ch=%0d pos=%0d last=%0b, want 1/%0d/%0d/0",
                 k, sample_valid, sample_ch, sample_pos, sample_last, hc, hp);
      end
    end
    sample_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (!sample_valid || sample_ch !== 2'd2 || sample_pos !== 32'd9) begin
      failures++;
      $display("FAIL bp_ch2: valid=%0b ch=%0d pos=%0d, want 1/2/9", sample_valid, sample_ch, sample_pos);
    end
    @(negedge clk);
    checks++;
    if (!sample_valid || sample_ch !== 2'd3 || sample_last !== 1'b1) begin
      failures++;
      $display("FAIL bp_ch3: valid=%0b ch=%0d last=%0b, want 1/3/1", sample_valid, sample_ch, sample_last);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_sat();
    logic [1:0] c; logic [31:0] p; logic [15:0] v; logic l;
    int ep [4]; int ev [4];
    do_reset();
    cnt = '{32'h7FFFFFFF, 0, 0, 0};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) get_rec(c, p, v, l);
    cnt[0] = 32'h80000000; cnt[1] = 40000;
    ep = '{32'h80000000, 40000, 0, 0}; ev = '{1, 32767, 0, 0};
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(ep[i]) || v !== 16'(ev[i])) begin
        failures++;
        $display("FAIL wrap_sat_up rec%0d: got ch=%0d pos=%h vel=%0d, want pos=%h vel=%0d",
                 i, c, p, $signed(v), ep[i], ev[i]);
      end
    end
    cnt[1] = 0;
    ep = '{32'h80000000, 0, 0, 0}; ev = '{0, -32768, 0, 0};
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(ep[i]) || v !== 16'(ev[i])) begin
        failures++;
        $display("FAIL wrap_sat_down rec%0d: got ch=%0d pos=%h vel=%0d, want pos=%h vel=%0d",
                 i, c, p, $signed(v), ep[i], ev[i]);
      end
    end
  endtask

  task automatic test_zero();
    logic [1:0] c; logic [31:0] p; logic [15:0] v; logic l;
    int ep [4]; int ev [4]; int n;
    do_reset();
    cnt = '{0, 0, 500, 0};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) get_rec(c, p, v, l);
    zero_req = 4'b0100;
    @(negedge clk);
    zero_req = '0;
    cnt[2] = 520;
    ep = '{0, 0, 20, 0}; ev = '{0, 0, 20, 0};
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(ep[i]) || v !== 16'(ev[i])) begin
        failures++;
        $display("FAIL zero_basic rec%0d: got ch=%0d pos=%0d vel=%0d, want pos=%0d vel=%0d",
                 i, c, p, $signed(v), ep[i], ev[i]);
      end
    end
    cnt[2] = 600;
    n = 0;
    while (!(busy && !sample_valid) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!(busy && !sample_valid)) begin failures++; $display("FAIL zero_snap_wait: snap cycle not seen"); end
    zero_req = 4'b0100;
    @(negedge clk);
    zero_req = '0;
    ep = '{0, 0, 100, 0}; ev = '{0, 0, 80, 0};
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(ep[i]) || v !== 16'(ev[i])) begin
        failures++;
        $display("FAIL zero_at_snap rec%0d: got ch=%0d pos=%0d vel=%0d, want pos=%0d vel=%0d",
                 i, c, p, $signed(v), ep[i], ev[i]);
      end
    end
    cnt[2] = 650;
    ep = '{0, 0, 50, 0}; ev = '{0, 0, 50, 0};
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(ep[i]) || v !== 16'(ev[i])) begin
        failures++;
        $display("FAIL zero_after_snap rec%0d: got ch=%0d pos=%0d vel=%0d, want pos=%0d vel=%0d",
                 i, c, p, $signed(v), ep[i], ev[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [1:0] c; logic [31:0] p; logic [15:0] v; logic l;
    bit seen;
    do_reset();
    cnt = '{1, 2, 3, 4};
    sample_ready = 1'b1;
    enable = 1'b1;
    wait_valid("endrop_start");
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(i + 1) || v !== 16'd0 || l !== (i == 3)) begin
        failures++;
        $display("FAIL endrop_stream rec%0d: got ch=%0d pos=%0d vel=%0d last=%0b, want pos=%0d vel=0",
                 i, c, p, $signed(v), l, i + 1);
      end
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sample_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL endrop_idle: activity seen=%0b, want 0", seen); end
    cnt = '{11, 12, 13, 14};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(i + 11) || v !== 16'd0) begin
        failures++;
        $display("FAIL endrop_reprime rec%0d: got ch=%0d pos=%0d vel=%0d, want pos=%0d vel=0",
                 i, c, p, $signed(v), i + 11);
      end
    end
  endtask

  task automatic test_overrun();
    logic [1:0] c; logic [31:0] p; logic [15:0] v; logic l;
    int ep [4]; int ev [4]; int n_ov;
    do_reset();
    cnt = '{1000, 2000, 3000, 4000};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) get_rec(c, p, v, l);
    cnt = '{1010, 2020, 3030, 4040};
    sample_ready = 1'b0;
    wait_valid("ov_stream2");
    n_ov = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (overrun) n_ov++;
      if (k == 3)  for (int j = 0; j < 4; j++) cnt[j] = cnt[j] + 1;
      if (k == 18) for (int j = 0; j < 4; j++) cnt[j] = cnt[j] + 2;
    end
    checks++;
    if (n_ov != 1 || overrun_cnt !== 8'd1) begin
      failures++;
      $display("FAIL ov_single: pulses=%0d cnt=%0d, want 1/1", n_ov, overrun_cnt);
    end
    ep = '{1010, 2020, 3030, 4040}; ev = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(ep[i]) || v !== 16'(ev[i])) begin
        failures++;
        $display("FAIL ov_held rec%0d: got ch=%0d pos=%0d vel=%0d, want pos=%0d vel=%0d",
                 i, c, p, $signed(v), ep[i], ev[i]);
      end
    end
    ep = '{1013, 2023, 3033, 4043}; ev = '{3, 3, 3, 3};
    for (int i = 0; i < 4; i++) begin
      get_rec(c, p, v, l);
      checks++;
      if (c !== 2'(i) || p !== 32'(ep[i]) || v !== 16'(ev[i])) begin
        failures++;
        $display("FAIL ov_twoper rec%0d: got ch=%0d pos=%0d vel=%0d, want pos=%0d vel=%0d",
                 i, c, p, $signed(v), ep[i], ev[i]);
      end
    end
    sample_ready = 1'b0;
    wait_valid("ov_sat_start");
    repeat (4900) @(negedge clk);
    checks++;
    if (overrun_cnt !== 8'd255 || !sample_valid || sample_ch !== 2'd0) begin
      failures++;
      $display("FAIL ov_saturate: cnt=%0d valid=%0b ch=%0d, want 255/1/0", overrun_cnt, sample_valid, sample_ch);
    end
  endtask

  task automatic test_reset_mid_emit();
    sample_ready = 1'b0;
    enable = 1'b1;
    wait_valid("rst_mid_start");
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sample_valid !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid_emit: valid=%0b busy=%0b ovc=%0d, want 0/0/0", sample_valid, busy, overrun_cnt);
    end
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_sat();
    test_zero();
    test_enable_drop();
    test_overrun();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
